// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Build option: define MULDIV_EARLY_TERM_EN to let MULT/MULTU stop once the remaining multiplier bits are zero.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_div0_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   // state | meaning
   // IDLE  | waiting for start_i; MTHI/MTLO and divide-by-zero complete here
   // CALC  | one radix-2 multiply or divide step per clock
   // FIX   | sign correction and HI/LO write-back
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 is_div;
   logic                 sign1;
   logic                 sign2;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;

   logic                 op_signed;
   logic                 op_div;
   logic [WIDTH-1:0]     src1_abs;
   logic [WIDTH-1:0]     src2_abs;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic                 div_ge;
   logic [WIDTH:0]       div_rem_next;
   logic [WIDTH-1:0]     quo_next;
   logic                 calc_last;
   logic                 neg_res;
   logic [2*WIDTH-1:0]   prod_raw;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;

   always_comb begin
      op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
      op_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
      src1_abs  = (op_signed && src1_i[WIDTH-1]) ? -src1_i : src1_i;
      src2_abs  = (op_signed && src2_i[WIDTH-1]) ? -src2_i : src2_i;

      // Multiply: add into the upper half, then shift the whole accumulator right.
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
      mul_next = {mul_sum, acc[WIDTH-1:1]};

      // Divide: acc[WIDTH:0] is the partial remainder, mplier shifts dividend out / quotient in.
      div_shift    = {acc[WIDTH-1:0], mplier[WIDTH-1]};
      div_ge       = (div_shift >= {1'b0, mcand});
      div_rem_next = div_ge ? (div_shift - {1'b0, mcand}) : div_shift;
      quo_next     = {mplier[WIDTH-2:0], div_ge};

`ifdef MULDIV_EARLY_TERM_EN
      calc_last = (cnt == CNT_W'(WIDTH-1)) || (!is_div && (mplier[WIDTH-1:1] == '0));
      // After cnt steps the product sits (WIDTH-cnt) bits too high.
      prod_raw  = acc >> (CNT_W'(WIDTH) - cnt);
`else
      calc_last = (cnt == CNT_W'(WIDTH-1));
      prod_raw  = acc;
`endif

      neg_res  = sign1 ^ sign2;
      prod_fix = neg_res ? -prod_raw : prod_raw;
      quo_fix  = neg_res ? -mplier : mplier;
      rem_fix  = sign1 ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         is_div     <= 1'b0;
         sign1      <= 1'b0;
         sign2      <= 1'b0;
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_div0_o <= 1'b0;
         hi_o       <= '0;
         lo_o       <= '0;
      end else begin
         done_o     <= 1'b0;
         err_div0_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  case (op_i)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        if (op_div && (src2_i == '0)) begin
                           hi_o       <= src1_i;
                           lo_o       <= {WIDTH{1'b1}};
                           done_o     <= 1'b1;
                           err_div0_o <= 1'b1;
                        end else begin
                           is_div <= op_div;
                           sign1  <= op_signed & src1_i[WIDTH-1];
                           sign2  <= op_signed & src2_i[WIDTH-1];
                           mcand  <= op_div ? src2_abs : src1_abs;
                           mplier <= op_div ? src1_abs : src2_abs;
                           acc    <= '0;
                           cnt    <= '0;
                           busy_o <= 1'b1;
                           state  <= ST_CALC;
                        end
                     end
                     OP_MTHI: begin
                        hi_o   <= src1_i;
                        done_o <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo_o   <= src1_i;
                        done_o <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_CALC: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  acc    <= {{(WIDTH-1){1'b0}}, div_rem_next};
                  mplier <= quo_next;
               end else begin
                  acc    <= mul_next;
                  mplier <= mplier >> 1;
               end
               if (calc_last) state <= ST_FIX;
            end
            ST_FIX: begin
               if (is_div) begin
                  hi_o <= rem_fix;
                  lo_o <= quo_fix;
               end else begin
                  hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_o <= prod_fix[WIDTH-1:0];
               end
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit (WIDTH=32) against a plain-arithmetic model.
// Honours MULDIV_EARLY_TERM_EN for the expected multiply latency.
module tb_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic        busy_o;
   logic        done_o;
   logic        err_div0_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .start_i    (start_i),
      .op_i       (op_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_div0_o (err_div0_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int top_bit(input logic [31:0] v);
      int h = 0;
      for (int i = 0; i < 32; i++) if (v[i]) h = i;
      return h;
   endfunction

   // Result from the architectural definition; lat = edges after the start edge until done.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic err, output int lat);
      longint      sa, sb, p;
      logic [63:0] u;
      logic [31:0] mag;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      err = 1'b0;
      lat = 33;
      hi  = exp_hi;
      lo  = exp_lo;
      case (op)
         3'd0: begin p = sa * sb; {hi, lo} = 64'(p); end
         3'd1: begin u = {32'b0, a} * {32'b0, b}; {hi, lo} = u; end
         3'd2, 3'd3: begin
            if (b == 0) begin
               hi = a; lo = '1; err = 1'b1; lat = 0;
            end else if (op == 3'd2) begin
               lo = 32'(sa / sb);
               hi = 32'(sa % sb);
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
         3'd4: begin hi = a; lat = 0; end
         3'd5: begin lo = a; lat = 0; end
         default: lat = -1;
      endcase
`ifdef MULDIV_EARLY_TERM_EN
      if (op <= 3'd1) begin
         mag = (op == 3'd0 && b[31]) ? -b : b;
         lat = 2 + top_bit(mag);
      end
`endif
   endtask

   // Issues one operation; intf=1 pokes a second start and an MTHI while busy.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit intf);
      logic [31:0] m_hi, m_lo;
      logic        m_err;
      int          lat, n, busy_cnt;
      bit          hold_ok, quiet;
      model(op, a, b, m_hi, m_lo, m_err, lat);
      @(negedge clk_i);
      start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
      @(posedge clk_i);
      #1;
      start_i = 1'b0; src1_i = $urandom; src2_i = $urandom;
      if (op >= 3'd6) begin
         quiet = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk_i); #1; end
            if (done_o || busy_o || err_div0_o || hi_o !== exp_hi || lo_o !== exp_lo) quiet = 1'b0;
         end
         check({tag, "_reserved_quiet"}, 64'(quiet), 64'd1);
         return;
      end
      busy_cnt = 0;
      hold_ok  = 1'b1;
      for (n = 0; n <= 100; n++) begin
         if (n > 0) begin @(posedge clk_i); #1; end
         if (busy_o) busy_cnt++;
         if (done_o) break;
         if (hi_o !== exp_hi || lo_o !== exp_lo || err_div0_o) hold_ok = 1'b0;
         if (intf) begin
            if (n == 3) begin start_i = 1'b1; op_i = 3'd1; src1_i = 32'd5; src2_i = 32'd5; end
            if (n == 4) begin op_i = 3'd4; src1_i = 32'h1234; end
            if (n == 5) start_i = 1'b0;
         end
      end
      start_i = 1'b0;
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_hi"}, 64'(hi_o), 64'(m_hi));
      check({tag, "_lo"}, 64'(lo_o), 64'(m_lo));
      check({tag, "_err"}, 64'(err_div0_o), 64'(m_err));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'((op <= 3'd3 && !m_err) ? lat : 0));
      if (lat > 0) check({tag, "_hold"}, 64'(hold_ok), 64'd1);
      exp_hi = m_hi;
      exp_lo = m_lo;
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [5];
      specials[0] = 32'h0;
      specials[1] = 32'h1;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
      return $urandom;
   endfunction

   initial begin
      rst_n_i = 1'b0;
      start_i = 1'b0;
      op_i    = '0;
      src1_i  = '0;
      src2_i  = '0;
      #12;
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_err", 64'(err_div0_o), 64'd0);
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_lo", 64'(lo_o), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("mult_neg", 3'd0, -32'sd3, 32'd7, 1'b0);
      run_op("div_neg", 3'd2, -32'sd7, 32'd2, 1'b0);
      run_op("divu_zero", 3'd3, 32'd100, 32'd0, 1'b0);
      run_op("div_ovf_intf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op("mthi", 3'd4, 32'hCAFE_0001, 32'd0, 1'b0);
      run_op("mtlo", 3'd5, 32'h0BAD_F00D, 32'd0, 1'b0);
      run_op("rsvd6", 3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0);

      // Abort a multiply mid-calculation with an asynchronous reset.
      @(negedge clk_i);
      start_i = 1'b1; op_i = 3'd1; src1_i = 32'hFFFF; src2_i = 32'hFFFF;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      check("abort_busy", 64'(busy_o), 64'd0);
      check("abort_done", 64'(done_o), 64'd0);
      check("abort_err", 64'(err_div0_o), 64'd0);
      check("abort_hi", 64'(hi_o), 64'd0);
      check("abort_lo", 64'(lo_o), 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      run_op("multu_6x7", 3'd1, 32'd6, 32'd7, 1'b0);
      run_op("multu_5x1", 3'd1, 32'd5, 32'd1, 1'b0);
      run_op("mult_by0", 3'd0, 32'h1234_5678, 32'd0, 1'b0);
      run_op("div_zero_s", 3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
